host_reg_slave: RTL and testbench

//  Register slave on the 16-bit host bus: clk, wr_n, address, bidirectional data.

---
 rtl/host_reg_pkg.sv | 37 +++
 rtl/host_tx_fifo.sv | 67 ++++++
 rtl/host_reg_slave.sv | 135 +++++++++++++
 tb/tb_host_reg_slave.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/host_reg_pkg.sv
// Host register slave: offsets, STATUS layout and reset constants.
package host_reg_pkg;

  typedef enum logic [3:0] {
    OFF_ID      = 4'h0,
    OFF_CTRL    = 4'h1,
    OFF_STATUS  = 4'h2,
    OFF_SCRATCH = 4'h3,
    OFF_TXDATA  = 4'h4,
    OFF_SNAP_LO = 4'h5,
    OFF_SNAP_HI = 4'h6
  } reg_off_e;

  localparam int EVT_LSB = 0;
  localparam int OVF_BIT = 8;
  localparam int LVL_LSB = 12;

  localparam int CTRL_CNT_EN = 0;
  localparam int CTRL_TX_EN  = 1;

  localparam logic [15:0] CHIP_ID_DEF = 16'h5A03;
  localparam logic [15:0] REG_RST     = 16'h0000;

  function automatic logic [15:0] status_word(
    input logic [7:0] evt,
    input logic       ovf,
    input logic [3:0] lvl
  );
    logic [15:0] s;
    s = '0;
    s[EVT_LSB +: 8] = evt;
    s[OVF_BIT]      = ovf;
    s[LVL_LSB +: 4] = lvl;
    return s;
  endfunction

endpackage

// File: rtl/host_tx_fifo.sv
// Small synchronous FIFO feeding the core-side TX port.
// Push is refused when full even if a pop happens on the same edge.
module host_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o,
  output logic [W-1:0]  head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          push_ok, pop_ok;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (lvl_q == LW'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    if (push_ok) wr_ptr_d = nxt(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = nxt(rd_ptr_q);
    unique case (1'b1)
      push_ok && !pop_ok: lvl_d = lvl_q + 1'b1;
      pop_ok && !push_ok: lvl_d = lvl_q - 1'b1;
      default:            lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/host_reg_slave.sv
// 16-word register window on the host bus: ID, control, sticky status,
// scratch, TX push FIFO and a free-running counter snapshot.
module host_reg_slave
  import host_reg_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter logic [15:0] CHIP_ID    = CHIP_ID_DEF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_n,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  input  logic [7:0]  event_in,
  output logic [15:0] ctrl_out,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic        hit;
  logic [3:0]  off;
  logic        wr_hit;
  logic [15:0] wdata;

  logic [15:0] ctrl_q, ctrl_d;
  logic [15:0] scratch_q, scratch_d;
  logic [7:0]  evt_q, evt_d;
  logic        ovf_q, ovf_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic [15:0] rd_q, rd_d;
  logic        rd_oe_q, rd_oe_d;
  logic [15:0] rd_mux;

  logic          push, pop, push_drop;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          bus_oe;

  assign hit    = (address[15:4] == BASE_ADDR[15:4]);
  assign off    = address[3:0];
  assign wr_hit = !wr_n && hit;
  assign wdata  = data;

  assign push      = wr_hit && (off == OFF_TXDATA);
  assign push_drop = push && fifo_full;
  assign tx_valid  = !fifo_empty && ctrl_q[CTRL_TX_EN];
  assign pop       = tx_valid && tx_ready;
  assign ctrl_out  = ctrl_q;

  host_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (wdata),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level),
    .head_o  (tx_data)
  );

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      off == OFF_ID:      rd_mux = CHIP_ID;
      off == OFF_CTRL:    rd_mux = ctrl_q;
      off == OFF_STATUS:  rd_mux = status_word(evt_q, ovf_q, 4'(fifo_level));
      off == OFF_SCRATCH: rd_mux = scratch_q;
      off == OFF_SNAP_LO: rd_mux = snap_q[15:0];
      off == OFF_SNAP_HI: rd_mux = snap_q[31:16];
      default:            rd_mux = '0;
    endcase
  end

  // Event sets are OR-ed in after the W1C mask so a same-edge set wins.
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    snap_d    = snap_q;
    evt_d     = evt_q;
    ovf_d     = ovf_q;
    cnt_d     = ctrl_q[CTRL_CNT_EN] ? cnt_q + 32'd1 : cnt_q;
    rd_d      = wr_n ? rd_mux : rd_q;
    rd_oe_d   = wr_n && hit;
    if (wr_hit) begin
      unique case (1'b1)
        off == OFF_CTRL:    ctrl_d    = wdata;
        off == OFF_SCRATCH: scratch_d = wdata;
        off == OFF_SNAP_LO: snap_d    = cnt_q;
        off == OFF_STATUS: begin
          evt_d = evt_q & ~wdata[EVT_LSB +: 8];
          ovf_d = ovf_q & ~wdata[OVF_BIT];
        end
        default: ;
      endcase
    end
    evt_d = evt_d | event_in;
    ovf_d = ovf_d | push_drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= REG_RST;
      scratch_q <= REG_RST;
      evt_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      snap_q    <= '0;
      rd_q      <= '0;
      rd_oe_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      evt_q     <= evt_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      rd_q      <= rd_d;
      rd_oe_q   <= rd_oe_d;
    end
  end

  assign bus_oe = rd_oe_q && wr_n && !reset;
  assign data   = bus_oe ? rd_q : 'z;

endmodule

// File: tb/tb_host_reg_slave.sv
// Table-driven bench for host_reg_slave with a read-data scoreboard.
module tb_host_reg_slave;

  localparam logic [11:0] BASE_HI = 12'h000;

  logic        clk;
  logic        reset;
  logic        wr_n;
  logic [15:0] address;
  wire  [15:0] data;
  logic [7:0]  event_in;
  logic [15:0] ctrl_out;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        tb_oe;
  logic [15:0] tb_wdata;

  assign data = tb_oe ? tb_wdata : 'z;

  host_reg_slave #(
    .BASE_ADDR  (16'h0000),
    .CHIP_ID    (16'h5A03),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_n     (wr_n),
    .address  (address),
    .data     (data),
    .event_in (event_in),
    .ctrl_out (ctrl_out),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rst;
    bit          wr_n;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [7:0]  evt;
    bit          rdy;
    bit          chk;
    logic [15:0] exp;
    bit          ctx;
    bit          tv;
    logic [15:0] td;
    string       name;
  } vec_t;

  typedef struct {
    bit          hit;
    bit          chk;
    logic [15:0] exp;
    string       name;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[$];
  int   checks;
  int   errors;

  function automatic vec_t mk(
    input bit rst, input bit wn, input logic [15:0] a,
    input logic [15:0] d, input logic [7:0] ev, input bit rdy,
    input bit chk, input logic [15:0] x, input bit ctx,
    input bit tv, input logic [15:0] td, input string n
  );
    vec_t v;
    v.rst = rst; v.wr_n = wn; v.addr = a; v.wd = d;
    v.evt = ev; v.rdy = rdy; v.chk = chk; v.exp = x;
    v.ctx = ctx; v.tv = tv; v.td = td; v.name = n;
    return v;
  endfunction

  function automatic vec_t rd(input logic [15:0] a,
                              input logic [15:0] x, input string n);
    return mk(0, 1, a, 16'h0, 8'h0, 0, 1, x, 0, 0, 16'h0, n);
  endfunction

  function automatic vec_t wr(input logic [15:0] a,
                              input logic [15:0] d, input string n);
    return mk(0, 0, a, d, 8'h0, 0, 0, 16'h0, 0, 0, 16'h0, n);
  endfunction

  function automatic vec_t nop(input string n);
    return rd(16'h000F, 16'h0000, n);
  endfunction

  task automatic cmp(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    sb_t e;
    bit  exp_drv;
    @(negedge clk);
    reset    = v.rst;
    wr_n     = v.wr_n;
    address  = v.addr;
    event_in = v.evt;
    tx_ready = v.rdy;
    tb_oe    = !v.wr_n;
    tb_wdata = v.wd;
    #1;
    e.hit = 0; e.chk = 0; e.exp = '0; e.name = "start";
    if (sbq.size() > 0) e = sbq.pop_front();
    exp_drv = e.hit && v.wr_n && !v.rst;
    cmp({e.name, "/oe"}, 32'(dut.bus_oe), 32'(exp_drv));
    if (exp_drv && e.chk) cmp(e.name, 32'(data), 32'(e.exp));
    if (v.ctx) begin
      cmp({v.name, "/tv"}, 32'(tx_valid), 32'(v.tv));
      if (v.tv) cmp({v.name, "/td"}, 32'(tx_data), 32'(v.td));
    end
    e.hit  = v.wr_n && !v.rst && (v.addr[15:4] == BASE_HI);
    e.chk  = v.chk;
    e.exp  = v.exp;
    e.name = v.name;
    sbq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; wr_n = 1'b1; address = '0; event_in = '0;
    tx_ready = 1'b0; tb_oe = 1'b0; tb_wdata = '0;

    tbl.push_back(mk(1, 1, 16'h0, 16'h0, 8'h0, 0, 0, 16'h0, 0, 0, 16'h0, "rst0"));
    tbl.push_back(mk(1, 1, 16'h0, 16'h0, 8'h0, 0, 0, 16'h0, 1, 0, 16'h0, "rst1"));
    tbl.push_back(rd(16'h0000, 16'h5A03, "id"));
    tbl.push_back(rd(16'h0001, 16'h0000, "ctrl_rst"));
    tbl.push_back(rd(16'h0002, 16'h0000, "st_rst"));
    tbl.push_back(nop("nop0"));
    tbl.push_back(wr(16'h0003, 16'hA5C3, "w_scr"));
    tbl.push_back(rd(16'h0003, 16'hA5C3, "scr"));
    tbl.push_back(rd(16'h0040, 16'h0000, "miss"));
    tbl.push_back(wr(16'h0040, 16'h1234, "w_miss"));
    tbl.push_back(rd(16'h0003, 16'hA5C3, "scr_keep"));
    tbl.push_back(rd(16'h0004, 16'h0000, "txd_rd"));
    tbl.push_back(rd(16'h000F, 16'h0000, "unmapped"));
    tbl.push_back(mk(0, 1, 16'h2, 16'h0, 8'h81, 0, 1, 16'h0000, 0, 0, 16'h0, "st_pre"));
    tbl.push_back(rd(16'h0002, 16'h0081, "st_evt"));
    tbl.push_back(nop("nop1"));
    tbl.push_back(mk(0, 0, 16'h2, 16'h0001, 8'h01, 0, 0, 16'h0, 0, 0, 16'h0, "w1c_race"));
    tbl.push_back(rd(16'h0002, 16'h0081, "set_wins"));
    tbl.push_back(nop("nop2"));
    tbl.push_back(wr(16'h0002, 16'h0001, "w1c0"));
    tbl.push_back(rd(16'h0002, 16'h0080, "st_80"));
    tbl.push_back(nop("nop3"));
    tbl.push_back(wr(16'h0002, 16'h0080, "w1c7"));
    tbl.push_back(rd(16'h0002, 16'h0000, "st_0"));
    tbl.push_back(nop("nop4"));
    tbl.push_back(wr(16'h0001, 16'h0002, "txen"));
    tbl.push_back(mk(0, 0, 16'h4, 16'h0001, 8'h0, 0, 0, 16'h0, 1, 0, 16'h0, "push1"));
    tbl.push_back(mk(0, 0, 16'h4, 16'h0002, 8'h0, 0, 0, 16'h0, 1, 1, 16'h1, "push2"));
    tbl.push_back(mk(0, 0, 16'h4, 16'h0003, 8'h0, 0, 0, 16'h0, 1, 1, 16'h1, "push3"));
    tbl.push_back(mk(0, 0, 16'h4, 16'h0004, 8'h0, 0, 0, 16'h0, 1, 1, 16'h1, "push4"));
    tbl.push_back(mk(0, 0, 16'h4, 16'h0005, 8'h0, 0, 0, 16'h0, 1, 1, 16'h1, "push5"));
    tbl.push_back(mk(0, 1, 16'h2, 16'h0, 8'h0, 0, 1, 16'h4100, 1, 1, 16'h1, "lvl4"));
    tbl.push_back(mk(0, 1, 16'h1, 16'h0, 8'h0, 0, 1, 16'h0002, 1, 1, 16'h1, "ctrl2"));
    tbl.push_back(mk(0, 1, 16'h0, 16'h0, 8'h0, 1, 1, 16'h5A03, 1, 1, 16'h1, "pop1"));
    tbl.push_back(mk(0, 1, 16'h0, 16'h0, 8'h0, 1, 1, 16'h5A03, 1, 1, 16'h2, "pop2"));
    tbl.push_back(mk(0, 1, 16'h0, 16'h0, 8'h0, 1, 1, 16'h5A03, 1, 1, 16'h3, "pop3"));
    tbl.push_back(mk(0, 1, 16'h0, 16'h0, 8'h0, 1, 1, 16'h5A03, 1, 1, 16'h4, "pop4"));
    tbl.push_back(mk(0, 1, 16'h2, 16'h0, 8'h0, 1, 1, 16'h0100, 1, 0, 16'h0, "drain"));
    tbl.push_back(nop("nop5"));
    tbl.push_back(wr(16'h0002, 16'h0100, "ovf_clr"));
    tbl.push_back(rd(16'h0002, 16'h0000, "st_clr"));
    tbl.push_back(nop("nop6"));
    tbl.push_back(wr(16'h0001, 16'h0000, "txoff"));
    tbl.push_back(wr(16'h0004, 16'h00AA, "push_aa"));
    tbl.push_back(mk(0, 1, 16'h2, 16'h0, 8'h0, 1, 1, 16'h1000, 1, 0, 16'h0, "hold"));
    tbl.push_back(nop("nop7"));
    tbl.push_back(mk(0, 0, 16'h1, 16'h0002, 8'h0, 0, 0, 16'h0, 1, 0, 16'h0, "txon"));
    tbl.push_back(mk(0, 1, 16'h0, 16'h0, 8'h0, 1, 1, 16'h5A03, 1, 1, 16'h00AA, "pop_aa"));
    tbl.push_back(mk(0, 1, 16'h2, 16'h0, 8'h0, 0, 1, 16'h0000, 1, 0, 16'h0, "empty"));
    tbl.push_back(nop("nop8"));

    foreach (tbl[i]) apply(tbl[i]);

    // counter wrap and pre-increment snapshot
    apply(wr(16'h0001, 16'h0001, "cnt_en"));
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    apply(nop("wrap1"));
    cmp("ctrl_out", 32'(ctrl_out), 32'h0001);
    apply(nop("wrap2"));
    apply(wr(16'h0005, 16'hFFFF, "snap0"));
    apply(rd(16'h0005, 16'h0000, "snap_lo0"));
    apply(rd(16'h0006, 16'h0000, "snap_hi0"));
    apply(nop("nop9"));
    apply(wr(16'h0005, 16'h0000, "snap1"));
    apply(rd(16'h0005, 16'h0004, "snap_lo1"));
    apply(rd(16'h0006, 16'h0000, "snap_hi1"));
    apply(nop("nop10"));

    // reset in the middle of a queued burst
    apply(wr(16'h0001, 16'h0002, "b_txen"));
    apply(wr(16'h0004, 16'h0011, "b_push1"));
    apply(wr(16'h0004, 16'h0022, "b_push2"));
    apply(mk(0, 1, 16'h0, 16'h0, 8'h0, 0, 0, 16'h0, 1, 1, 16'h0011, "b_q2"));
    apply(mk(1, 1, 16'h1, 16'h0, 8'h0, 0, 0, 16'h0, 1, 1, 16'h0011, "rst_mid"));
    apply(mk(0, 1, 16'h1, 16'h0, 8'h0, 0, 1, 16'h0000, 1, 0, 16'h0, "post_rst"));
    cmp("ctrl_out_rst", 32'(ctrl_out), 32'h0000);
    apply(rd(16'h0002, 16'h0000, "st_post"));
    apply(rd(16'h0000, 16'h5A03, "id_post"));
    apply(mk(0, 1, 16'hF, 16'h0, 8'h0, 1, 1, 16'h0, 1, 0, 16'h0, "final"));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
